// File: rtl/servo_xy_ramp_ctrl.sv
`timescale 1ns/1ps
// Two-channel servo setpoint controller: clamps width commands and slews each
// channel toward its target by at most STEP_TICKS, updating only at frame ends.
module servo_xy_ramp_ctrl #(
    parameter int CNT_WIDTH       = 20,
    parameter int FRAME_TICKS     = 1_000_000,
    parameter int PULSE_MIN_TICKS = 50_000,
    parameter int PULSE_MAX_TICKS = 100_000,
    parameter int STEP_TICKS      = 500
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_chan_i,
    input  logic [CNT_WIDTH-1:0] cmd_width_i,
    output logic [CNT_WIDTH-1:0] width_x_o,
    output logic [CNT_WIDTH-1:0] width_y_o,
    output logic                 busy_x_o,
    output logic                 busy_y_o,
    output logic                 frame_tick_o,
    output logic                 clamp_o
);

    typedef enum logic [1:0] {HOLD, RAMP_UP, RAMP_DN} state_t;

    localparam logic [CNT_WIDTH-1:0] LAST     = CNT_WIDTH'(FRAME_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] BLACKOUT = CNT_WIDTH'(FRAME_TICKS - 2);
    localparam logic [CNT_WIDTH-1:0] W_MIN    = CNT_WIDTH'(PULSE_MIN_TICKS);
    localparam logic [CNT_WIDTH-1:0] W_MAX    = CNT_WIDTH'(PULSE_MAX_TICKS);
    localparam logic [CNT_WIDTH-1:0] STEP_N   = CNT_WIDTH'(STEP_TICKS);
    localparam logic [CNT_WIDTH:0]   STEP_W   = (CNT_WIDTH + 1)'(STEP_TICKS);

    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic                 ready_q;
    logic                 tick_q;
    logic                 accept;
    logic                 clamped;
    logic [CNT_WIDTH-1:0] width_clamped;

    logic [CNT_WIDTH-1:0] tgt      [2];
    logic [CNT_WIDTH-1:0] cur      [2];
    logic [CNT_WIDTH-1:0] cur_next [2];
    logic [CNT_WIDTH:0]   up_sum   [2];
    logic [CNT_WIDTH:0]   dn_floor [2];
    state_t               state      [2];
    state_t               state_next [2];

    assign cnt_next = (cnt == LAST) ? '0 : cnt + CNT_WIDTH'(1);

    // Ready and tick are registered from the next count so both read 0 in reset.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt     <= '0;
            ready_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            cnt     <= cnt_next;
            ready_q <= (cnt_next < BLACKOUT);
            tick_q  <= (cnt_next == LAST);
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latch).
        clamped       = 1'b0;
        width_clamped = cmd_width_i;
        if (cmd_width_i < W_MIN) begin
            clamped       = 1'b1;
            width_clamped = W_MIN;
        end else if (cmd_width_i > W_MAX) begin
            clamped       = 1'b1;
            width_clamped = W_MAX;
        end
    end

    assign accept = cmd_valid_i & ready_q;

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            up_sum[c]     = {1'b0, cur[c]} + STEP_W;
            dn_floor[c]   = {1'b0, tgt[c]} + STEP_W;
            state_next[c] = HOLD;
            if (tgt[c] > cur[c]) begin
                state_next[c] = RAMP_UP;
            end else if (tgt[c] < cur[c]) begin
                state_next[c] = RAMP_DN;
            end
            cur_next[c] = cur[c];
            case (state[c])
                RAMP_UP: cur_next[c] = (up_sum[c] > {1'b0, tgt[c]}) ? tgt[c]
                                                                    : up_sum[c][CNT_WIDTH-1:0];
                RAMP_DN: cur_next[c] = ({1'b0, cur[c]} >= dn_floor[c]) ? cur[c] - STEP_N
                                                                       : tgt[c];
                default: cur_next[c] = cur[c];
            endcase
        end
    end

    // Widths move only on the edge closing the frame-tick cycle.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int c = 0; c < 2; c++) begin
                tgt[c]   <= W_MIN;
                cur[c]   <= W_MIN;
                state[c] <= HOLD;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                state[c] <= state_next[c];
                if (tick_q) begin
                    cur[c] <= cur_next[c];
                end
                if (accept && (cmd_chan_i == 1'(c))) begin
                    tgt[c] <= width_clamped;
                end
            end
        end
    end

    assign cmd_ready_o  = ready_q;
    assign frame_tick_o = tick_q;
    assign clamp_o      = accept & clamped;
    assign width_x_o    = cur[0];
    assign width_y_o    = cur[1];
    assign busy_x_o     = (state[0] != HOLD);
    assign busy_y_o     = (state[1] != HOLD);

endmodule

// File: tb/tb_servo_xy_ramp_ctrl.sv
`timescale 1ns/1ps
// Bench for servo_xy_ramp_ctrl with a small frame: directed scenarios against
// fixed expectations plus random commands against a frame-level model.
module tb_servo_xy_ramp_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_chan;
    logic [19:0] cmd_width;
    logic [19:0] width_x;
    logic [19:0] width_y;
    logic        busy_x;
    logic        busy_y;
    logic        frame_tick;
    logic        clamp;

    int total = 0;
    int bad   = 0;

    servo_xy_ramp_ctrl #(
        .CNT_WIDTH      (20),
        .FRAME_TICKS    (100),
        .PULSE_MIN_TICKS(10),
        .PULSE_MAX_TICKS(20),
        .STEP_TICKS     (3)
    ) dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_chan_i  (cmd_chan),
        .cmd_width_i (cmd_width),
        .width_x_o   (width_x),
        .width_y_o   (width_y),
        .busy_x_o    (busy_x),
        .busy_y_o    (busy_y),
        .frame_tick_o(frame_tick),
        .clamp_o     (clamp)
    );

    always #5 clk = ~clk;

    // Reference model: k counts clock edges since reset release; the frame
    // position is k mod 100. Widths move toward the target at frame ends.
    int          k = 0;
    logic [19:0] m_tgt  [2];
    logic [19:0] m_cur  [2];
    logic        m_busy [2];

    function automatic logic exp_ready(input int kk);
        return (kk > 0) && ((kk % 100) < 98);
    endfunction

    function automatic logic exp_tick(input int kk);
        return (kk % 100) == 99;
    endfunction

    function automatic logic [19:0] clampw(input logic [19:0] w);
        if (w < 20'd10) return 20'd10;
        if (w > 20'd20) return 20'd20;
        return w;
    endfunction

    always @(posedge clk or negedge reset_n) begin : model
        logic nb [2];
        if (!reset_n) begin
            k = 0;
            for (int c = 0; c < 2; c++) begin
                m_tgt[c]  = 20'd10;
                m_cur[c]  = 20'd10;
                m_busy[c] = 1'b0;
            end
        end else begin
            for (int c = 0; c < 2; c++) nb[c] = (m_tgt[c] != m_cur[c]);
            if (exp_tick(k)) begin
                for (int c = 0; c < 2; c++) begin
                    if (m_tgt[c] > m_cur[c])
                        m_cur[c] = (m_tgt[c] - m_cur[c] > 20'd3) ? m_cur[c] + 20'd3 : m_tgt[c];
                    else if (m_tgt[c] < m_cur[c])
                        m_cur[c] = (m_cur[c] - m_tgt[c] > 20'd3) ? m_cur[c] - 20'd3 : m_tgt[c];
                end
            end
            if (cmd_valid && exp_ready(k)) m_tgt[cmd_chan] = clampw(cmd_width);
            for (int c = 0; c < 2; c++) m_busy[c] = nb[c];
            k = k + 1;
        end
    end

    task automatic wait_pos(input int p);
        @(negedge clk);
        while ((k % 100) != p) @(negedge clk);
    endtask

    task automatic send(input logic chan, input logic [19:0] w);
        cmd_valid = 1'b1;
        cmd_chan  = chan;
        cmd_width = w;
    endtask

    task automatic test_reset();
        int ticks;
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_chan  = 1'b0;
        cmd_width = '0;
        repeat (3) @(negedge clk);
        total++; if (width_x !== 20'd10) begin bad++; $display("FAIL reset_width_x: got %0d want 10", width_x); end
        total++; if (width_y !== 20'd10) begin bad++; $display("FAIL reset_width_y: got %0d want 10", width_y); end
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", cmd_ready); end
        total++; if (frame_tick !== 1'b0) begin bad++; $display("FAIL reset_tick: got %b want 0", frame_tick); end
        total++; if ({busy_x, busy_y} !== 2'b00) begin bad++; $display("FAIL reset_busy: got %b want 00", {busy_x, busy_y}); end
        #2 reset_n = 1'b1;
        ticks = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) ticks++;
            total++; if (frame_tick !== exp_tick(k)) begin bad++; $display("FAIL frame_tick k=%0d: got %b want %b", k, frame_tick, exp_tick(k)); end
            total++; if (cmd_ready !== exp_ready(k)) begin bad++; $display("FAIL ready k=%0d: got %b want %b", k, cmd_ready, exp_ready(k)); end
        end
        total++; if (ticks != 3) begin bad++; $display("FAIL tick_count: got %0d want 3", ticks); end
    endtask

    task automatic test_ramp_up();
        logic [19:0] seq [4];
        logic [19:0] prev;
        seq  = '{20'd13, 20'd16, 20'd19, 20'd20};
        prev = 20'd10;
        wait_pos(5);
        send(1'b0, 20'd20);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        total++; if (busy_x !== 1'b1) begin bad++; $display("FAIL ramp_busy_rise: got %b want 1", busy_x); end
        for (int i = 0; i < 4; i++) begin
            wait_pos(50);
            total++; if (width_x !== prev) begin bad++; $display("FAIL ramp_midframe: got %0d want %0d", width_x, prev); end
            wait_pos(0);
            total++; if (width_x !== seq[i]) begin bad++; $display("FAIL ramp_x step%0d: got %0d want %0d", i, width_x, seq[i]); end
            total++; if (width_y !== 20'd10) begin bad++; $display("FAIL ramp_y_static: got %0d want 10", width_y); end
            prev = seq[i];
        end
        total++; if (busy_x !== 1'b1) begin bad++; $display("FAIL ramp_busy_at_final: got %b want 1", busy_x); end
        @(negedge clk);
        total++; if (busy_x !== 1'b0) begin bad++; $display("FAIL ramp_busy_fall: got %b want 0", busy_x); end
    endtask

    task automatic test_clamp();
        logic [19:0] seq [4];
        seq = '{20'd13, 20'd16, 20'd19, 20'd20};
        wait_pos(5);
        send(1'b1, 20'd5);
        #1;
        total++; if (clamp !== 1'b1) begin bad++; $display("FAIL clamp_low_pulse: got %b want 1", clamp); end
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        total++; if (clamp !== 1'b0) begin bad++; $display("FAIL clamp_low_end: got %b want 0", clamp); end
        wait_pos(50);
        total++; if (busy_y !== 1'b0) begin bad++; $display("FAIL clamp_low_busy: got %b want 0", busy_y); end
        wait_pos(0);
        total++; if (width_y !== 20'd10) begin bad++; $display("FAIL clamp_low_width: got %0d want 10", width_y); end
        wait_pos(5);
        send(1'b1, 20'd30);
        #1;
        total++; if (clamp !== 1'b1) begin bad++; $display("FAIL clamp_high_pulse: got %b want 1", clamp); end
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_pos(0);
            total++; if (width_y !== seq[i]) begin bad++; $display("FAIL clamp_high_y step%0d: got %0d want %0d", i, width_y, seq[i]); end
            total++; if (width_x !== 20'd20) begin bad++; $display("FAIL clamp_x_static: got %0d want 20", width_x); end
        end
    endtask

    task automatic test_back_to_back();
        wait_pos(10);
        send(1'b0, 20'd12);
        @(negedge clk);
        send(1'b0, 20'd18);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_pos(0);
        total++; if (width_x !== 20'd18) begin bad++; $display("FAIL b2b_last_wins: got %0d want 18", width_x); end
        wait_pos(5);
        total++; if (busy_x !== 1'b0) begin bad++; $display("FAIL b2b_settled: got %b want 0", busy_x); end
    endtask

    task automatic test_reversal();
        wait_pos(5);
        send(1'b0, 20'd10);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) wait_pos(0);
        total++; if (width_x !== 20'd10) begin bad++; $display("FAIL rev_down_to_min: got %0d want 10", width_x); end
        wait_pos(5);
        send(1'b0, 20'd20);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) wait_pos(0);
        total++; if (width_x !== 20'd16) begin bad++; $display("FAIL rev_setup: got %0d want 16", width_x); end
        wait_pos(5);
        send(1'b0, 20'd12);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_pos(0);
        total++; if (width_x !== 20'd13) begin bad++; $display("FAIL rev_first: got %0d want 13", width_x); end
        wait_pos(0);
        total++; if (width_x !== 20'd12) begin bad++; $display("FAIL rev_second: got %0d want 12", width_x); end
        @(negedge clk);
        total++; if (busy_x !== 1'b0) begin bad++; $display("FAIL rev_hold: got %b want 0", busy_x); end
        wait_pos(0);
        total++; if (width_x !== 20'd12) begin bad++; $display("FAIL rev_stays: got %0d want 12", width_x); end
    endtask

    task automatic test_async_reset();
        wait_pos(5);
        send(1'b0, 20'd10);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_pos(5);
        send(1'b0, 20'd20);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) wait_pos(0);
        wait_pos(50);
        total++; if (width_x !== 20'd16 || busy_x !== 1'b1) begin bad++; $display("FAIL areset_setup: got %0d/%b want 16/1", width_x, busy_x); end
        #2 reset_n = 1'b0;
        #1;
        total++; if (width_x !== 20'd10) begin bad++; $display("FAIL areset_width: got %0d want 10", width_x); end
        total++; if (busy_x !== 1'b0) begin bad++; $display("FAIL areset_busy: got %b want 0", busy_x); end
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL areset_ready: got %b want 0", cmd_ready); end
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_pos(0);
            total++; if (width_x !== 20'd10 || busy_x !== 1'b0) begin bad++; $display("FAIL areset_no_resume: got %0d/%b want 10/0", width_x, busy_x); end
        end
    endtask

    task automatic test_blackout();
        wait_pos(98);
        send(1'b0, 20'd14);
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL blackout_98: got %b want 0", cmd_ready); end
        @(negedge clk);
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL blackout_99: got %b want 0", cmd_ready); end
        @(negedge clk);
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL blackout_ready0: got %b want 1", cmd_ready); end
        total++; if (width_x !== 20'd10) begin bad++; $display("FAIL blackout_not_taken: got %0d want 10", width_x); end
        @(negedge clk);
        cmd_valid = 1'b0;
        total++; if (busy_x !== 1'b0) begin bad++; $display("FAIL blackout_busy_pos1: got %b want 0", busy_x); end
        @(negedge clk);
        total++; if (busy_x !== 1'b1) begin bad++; $display("FAIL blackout_busy_pos2: got %b want 1", busy_x); end
        wait_pos(0);
        total++; if (width_x !== 20'd13) begin bad++; $display("FAIL blackout_effect: got %0d want 13", width_x); end
    endtask

    task automatic test_random();
        logic exp_clamp;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!(cmd_valid && !exp_ready(k - 1))) begin
                cmd_valid = ($urandom_range(0, 3) == 0);
                cmd_chan  = 1'($urandom_range(0, 1));
                cmd_width = ($urandom_range(0, 7) == 0) ? 20'($urandom) : 20'($urandom_range(0, 31));
            end
            #1;
            exp_clamp = cmd_valid && exp_ready(k) && (cmd_width < 20'd10 || cmd_width > 20'd20);
            total++; if (clamp !== exp_clamp) begin bad++; $display("FAIL rnd_clamp k=%0d: got %b want %b", k, clamp, exp_clamp); end
            total++; if (width_x !== m_cur[0]) begin bad++; $display("FAIL rnd_width_x k=%0d: got %0d want %0d", k, width_x, m_cur[0]); end
            total++; if (width_y !== m_cur[1]) begin bad++; $display("FAIL rnd_width_y k=%0d: got %0d want %0d", k, width_y, m_cur[1]); end
            total++; if (busy_x !== m_busy[0]) begin bad++; $display("FAIL rnd_busy_x k=%0d: got %b want %b", k, busy_x, m_busy[0]); end
            total++; if (busy_y !== m_busy[1]) begin bad++; $display("FAIL rnd_busy_y k=%0d: got %b want %b", k, busy_y, m_busy[1]); end
            total++; if (cmd_ready !== exp_ready(k)) begin bad++; $display("FAIL rnd_ready k=%0d: got %b want %b", k, cmd_ready, exp_ready(k)); end
            total++; if (frame_tick !== exp_tick(k)) begin bad++; $display("FAIL rnd_tick k=%0d: got %b want %b", k, frame_tick, exp_tick(k)); end
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_clamp();
        test_back_to_back();
        test_reversal();
        test_async_reset();
        test_blackout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/servo_xy_ramp_ctrl.md
Name: servo_xy_ramp_ctrl

Overview:
- Setpoint controller sitting in front of the two pwm_servo channels (X, Y).
- Accepts per-channel pulse-width commands over a valid/ready handshake and clamps them to the legal servo range.
- Slews each channel's width toward its target by a fixed step once per 20 ms frame.
- Presents frame-aligned width_x_o/width_y_o that feed the PWM channels' width inputs.

Parameters:
CNT_WIDTH, 20, width of all tick counts and width buses
FRAME_TICKS, 1_000_000, frame length in clk_i cycles (>= 4)
PULSE_MIN_TICKS, 50_000, minimum legal width (1.0 ms)
PULSE_MAX_TICKS, 100_000, maximum legal width (2.0 ms)
STEP_TICKS, 500, maximum width change per frame (>= 1)

Ports:
clk_i  input  1  system clock, 50 MHz
reset_n_i  input  1  asynchronous active-low reset
cmd_valid_i  input  1  command valid
cmd_ready_o  output  1  command ready; transfer when valid & ready
cmd_chan_i  input  1  target channel: 0 = X, 1 = Y
cmd_width_i  input  CNT_WIDTH  requested width in ticks
width_x_o  output  CNT_WIDTH  current X width to PWM channel
width_y_o  output  CNT_WIDTH  current Y width to PWM channel
busy_x_o  output  1  X not yet at target
busy_y_o  output  1  Y not yet at target
frame_tick_o  output  1  one-cycle pulse, last cycle of each frame
clamp_o  output  1  one-cycle pulse: last accepted command was clamped

Behaviour:
- Reset (async assert, sync-safe deassert) forces:
  - frame counter = 0; frame_tick_o = 0; cmd_ready_o = 0; clamp_o = 0.
  - width_*_o and targets = PULSE_MIN_TICKS; both channel FSMs in HOLD; busy_*_o = 0.
- Frame counter:
  - Runs 0..FRAME_TICKS-1, then wraps to 0.
  - frame_tick_o = 1 exactly when counter == FRAME_TICKS-1.
- Handshake:
  - cmd_ready_o = 1 except when counter >= FRAME_TICKS-2 (last two cycles of the frame) and during reset.
  - cmd_ready_o is independent of cmd_valid_i and cmd_chan_i.
  - A stalled command must be held by the sender.
- Accept (valid & ready):
  - Clamp cmd_width_i to [PULSE_MIN_TICKS, PULSE_MAX_TICKS] and store it in the addressed channel's target register on the next edge.
  - clamp_o pulses in that same cycle if the value was altered.
  - A new command overwrites any pending target; a ramp in progress continues from the present width toward the new target.
- Per-channel FSM, states HOLD, RAMP_UP, RAMP_DN:
  - Re-evaluated every cycle from the registered target and width, one cycle after the target changes: tgt > cur → RAMP_UP; tgt < cur → RAMP_DN; else HOLD.
  - The two-cycle ready blackout guarantees the FSM state is settled before frame_tick_o.
- Update on the edge ending a frame_tick_o cycle, so the new width is visible from counter 0:
  - RAMP_UP: cur <= min(cur + STEP_TICKS, tgt).
  - RAMP_DN: cur <= max(cur - STEP_TICKS, tgt).
  - HOLD: no change.
  - Sums are computed at CNT_WIDTH+1 bits; the subtract saturates and never wraps below tgt.
- Timing guarantees:
  - width_*_o never change at any other time, so PWM pulses are never truncated mid-frame.
  - busy_*_o = (state != HOLD), registered, and falls in the cycle after the final step.
- Channels are fully independent. Two commands to the same channel in consecutive cycles: the last one wins.
- Reset asserted mid-ramp: all outputs return to their reset values immediately, with no clock required.

Test Plan:
(Sim parameters: FRAME_TICKS=100, MIN=10, MAX=20, STEP=3.)
- Reset release:
  - Before release: width_x_o = width_y_o = 10; cmd_ready_o = 0.
  - After release: frame_tick_o high at counter 99, 199, 299; cmd_ready_o low at counters 98 and 99 of every frame.
- Ramp up, cmd X=20 at counter 5:
  - busy_x_o rises.
  - width_x_o reads 13, 16, 19, 20 at the starts of successive frames.
  - busy_x_o falls one cycle after reaching 20.
  - width_y_o stays 10 throughout.
- Clamp, cmd Y=5:
  - clamp_o pulses one cycle; target = 10; width_y_o stays 10; busy_y_o stays 0.
  - Follow with cmd Y=30: clamp_o pulses; Y ramps 13, 16, 19, 20.
- Reversal: X at 16 ramping to 20, cmd X=12 → next frames give 13, then 12, then HOLD.
- Blackout: cmd_valid_i held from counter 98 → not accepted at 98 or 99; accepted at counter 0; takes effect at the next frame tick.
- Async reset mid-ramp (width_x_o = 16): reset_n_i low between clock edges → width_x_o = 10 and busy_x_o = 0 immediately; the ramp does not resume after release.
